access_controller: RTL
======================

Name: access_controller

Overview:
- Downstream consumer of the keypad code-checker stage. It takes the checker's 3-bit one-hot result (GRANT 3'b010, DENY 3'b100, IDLE 3'b000) plus a one-cycle strobe.
- Drives a timed unlock output, counts consecutive denials, and enforces a timed lockout with a blinking indicator after MAX_FAILS denials.
- Sits between the code checker and the board LEDs/actuator.

Parameters:
- MAX_FAILS, 3, consecutive denials that trigger lockout (>=1).
- UNLOCK_CYCLES, 50_000_000, clk cycles unlocked is held after a grant (>=1).
- LOCK_CYCLES, 100_000_000, clk cycles of lockout (>=1).
- BLINK_HALF, 12_500_000, clk cycles per half-period of led_blink during lockout (>=1).
- CNT_W, 27, timer width; must hold max(UNLOCK_CYCLES, LOCK_CYCLES, BLINK_HALF)-1.

Ports:
- clk, input, 1, system clock, all logic on rising edge.
- reset, input, 1, asynchronous, active-high; clears all state.
- result, input, 3, checker result code; sampled only when result_stb=1.
- result_stb, input, 1, one-cycle pulse; asserted the cycle after the checker updates result.
- unlocked, output, 1, high while in UNLOCKED.
- locked_out, output, 1, high while in LOCKED.
- fail_count, output, $clog2(MAX_FAILS+1), consecutive-denial count.
- led_blink, output, 1, square wave in LOCKED, 0 otherwise.
- bad_result, output, 1, one-cycle pulse when a strobed code is not GRANT/DENY/IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE, fail_count=0, timers=0; all outputs 0.
- All outputs are registered. Response appears the cycle after the result_stb cycle (latency 1).
- States: IDLE, UNLOCKED, LOCKED.
- IDLE, stb with GRANT: go to UNLOCKED; load timer UNLOCK_CYCLES-1; fail_count=0.
- IDLE, stb with DENY:
  - If fail_count+1 == MAX_FAILS: go to LOCKED; load timer LOCK_CYCLES-1; fail_count=MAX_FAILS; led_blink=1; load blink counter BLINK_HALF-1.
  - Else: fail_count+1 and stay in IDLE.
- IDLE, stb with IDLE code: no effect.
- Any state, stb with any other code (001, 011, 101, 110, 111): bad_result=1 for one cycle; no state or counter change. This includes LOCKED.
- UNLOCKED:
  - unlocked=1; timer decrements each cycle; timer==0 -> IDLE next cycle, so unlocked lasts exactly UNLOCK_CYCLES cycles.
  - stb GRANT: reload UNLOCK_CYCLES-1 (extend).
  - stb DENY: go to IDLE immediately with fail_count=1, or go to LOCKED if MAX_FAILS==1.
  - A strobe takes priority over timer expiry in the same cycle.
- LOCKED:
  - locked_out=1; GRANT/DENY/IDLE strobes are ignored.
  - Timer decrements; timer==0 -> IDLE with fail_count=0, led_blink=0, so locked_out lasts exactly LOCK_CYCLES cycles.
  - Blink counter decrements; at 0 it toggles led_blink and reloads BLINK_HALF-1.
- fail_count saturates at MAX_FAILS and never wraps.
- Reset mid-UNLOCKED or mid-LOCKED returns to IDLE at once with all outputs 0.
- result is don't-care when result_stb=0. X on result with stb=0 must not propagate.

Decomposition:
- Shared package access_pkg holds:
  - result codes RES_IDLE=3'b000, RES_GRANT=3'b010, RES_DENY=3'b100;
  - state encoding ST_IDLE, ST_UNLOCKED, ST_LOCKED (2-bit).
- The package is shared with the code checker so both stages agree on the codes.
- One sub-module, cycle_timer:
  - CNT_W-bit loadable down-counter with load, load_val and en inputs and a zero flag;
  - instantiated twice, for the state timer and the blink timer.
- FSM and fail counter live in access_controller.

Test Plan (MAX_FAILS=3, UNLOCK_CYCLES=8, LOCK_CYCLES=20, BLINK_HALF=4):
- Reset, then stb GRANT -> unlocked=1 from the next cycle for exactly 8 cycles, then 0; fail_count stays 0.
- Three stb DENY 5 cycles apart -> fail_count 1, 2, then locked_out=1. led_blink toggles every 4 cycles (1,0,1,0,1). locked_out clears after exactly 20 cycles with fail_count=0.
- DENY, DENY, GRANT -> fail_count 1, 2, then 0 with unlocked=1. A following DENY gives fail_count=1, not lockout.
- During LOCKED, stb GRANT and stb 3'b111 -> no state change; bad_result pulses once, for the 3'b111 strobe only.
- In UNLOCKED with timer at 2, stb GRANT -> unlocked stays high 8 more cycles. stb DENY in UNLOCKED -> unlocked=0 next cycle, fail_count=1.
- Assert reset at cycle 10 of LOCKED -> locked_out, led_blink and fail_count go to 0 asynchronously. The next stb GRANT unlocks normally.

Source files
------------

// File: rtl/access_pkg.sv
// Result codes and state encoding shared by the keypad code checker and the
// access controller, so both stages agree on what a strobed code means.
package access_pkg;

  localparam logic [2:0] RES_IDLE  = 3'b000;
  localparam logic [2:0] RES_GRANT = 3'b010;
  localparam logic [2:0] RES_DENY  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_LOCKED   = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_GRANT,
    EV_DENY,
    EV_BAD
  } event_t;

  // result is only looked at while the strobe is high, so X on an idle bus stays contained
  function automatic event_t classify(input logic stb, input logic [2:0] code);
    event_t ev;
    ev = EV_NONE;
    if (stb) begin
      case (code)
        RES_IDLE:  ev = EV_NONE;
        RES_GRANT: ev = EV_GRANT;
        RES_DENY:  ev = EV_DENY;
        default:   ev = EV_BAD;
      endcase
    end
    return ev;
  endfunction

endpackage

// File: rtl/access_controller_if.sv
// Result handshake from the code checker (master) to the access controller (slave).
interface access_controller_if;
  logic [2:0] result;
  logic       result_stb;

  modport master (output result, output result_stb);
  modport slave  (input  result, input  result_stb);
endinterface

// File: rtl/cycle_timer.sv
// Loadable down-counter that parks at zero; load wins over count enable.
module cycle_timer #(
  parameter int unsigned CNT_W = 27
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/access_controller.sv
// Timed unlock / consecutive-denial lockout stage driven by the code checker's
// strobed result; all state responds one cycle after the strobe.
module access_controller
  import access_pkg::*;
#(
  parameter int unsigned MAX_FAILS     = 3,
  parameter int unsigned UNLOCK_CYCLES = 50_000_000,
  parameter int unsigned LOCK_CYCLES   = 100_000_000,
  parameter int unsigned BLINK_HALF    = 12_500_000,
  parameter int unsigned CNT_W         = 27
) (
  input  logic                             clk,
  input  logic                             reset,
  access_controller_if.slave               chk,
  output logic                             unlocked,
  output logic                             locked_out,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count,
  output logic                             led_blink,
  output logic                             bad_result
);

  localparam int unsigned      FW        = $clog2(MAX_FAILS + 1);
  localparam logic [CNT_W-1:0] UNLOCK_LD = CNT_W'(UNLOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LD   = CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLINK_LD  = CNT_W'(BLINK_HALF - 1);

  state_t           state, state_nx;
  event_t           ev;
  logic [FW-1:0]    fail_nx;
  logic             blink_nx;
  logic             deny_locks;
  logic             tmr_load, tmr_zero;
  logic [CNT_W-1:0] tmr_val;
  logic             blk_load, blk_zero;
  logic [CNT_W-1:0] blk_val;

  assign ev         = classify(chk.result_stb, chk.result);
  assign deny_locks = (32'(fail_count) + 32'd1 >= MAX_FAILS);

  cycle_timer #(.CNT_W(CNT_W)) u_state_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (state != ST_IDLE),
    .zero     (tmr_zero)
  );

  cycle_timer #(.CNT_W(CNT_W)) u_blink_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (blk_load),
    .load_val (blk_val),
    .en       (state == ST_LOCKED),
    .zero     (blk_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      fail_count <= '0;
      led_blink  <= 1'b0;
      bad_result <= 1'b0;
    end else begin
      state      <= state_nx;
      fail_count <= fail_nx;
      led_blink  <= blink_nx;
      bad_result <= (ev == EV_BAD);
    end
  end

  // IDLE and UNLOCKED share strobe handling; expiry is set first so a strobe overrides it
  always_comb begin
    state_nx = state;
    fail_nx  = fail_count;
    blink_nx = led_blink;
    tmr_load = 1'b0;
    tmr_val  = '0;
    blk_load = 1'b0;
    blk_val  = '0;
    case (state)
      ST_IDLE, ST_UNLOCKED: begin
        if ((state == ST_UNLOCKED) && tmr_zero) begin
          state_nx = ST_IDLE;
        end
        if (ev == EV_GRANT) begin
          state_nx = ST_UNLOCKED;
          fail_nx  = '0;
          tmr_load = 1'b1;
          tmr_val  = UNLOCK_LD;
        end else if (ev == EV_DENY) begin
          if (deny_locks) begin
            state_nx = ST_LOCKED;
            fail_nx  = FW'(MAX_FAILS);
            tmr_load = 1'b1;
            tmr_val  = LOCK_LD;
            blk_load = 1'b1;
            blk_val  = BLINK_LD;
            blink_nx = 1'b1;
          end else begin
            state_nx = ST_IDLE;
            fail_nx  = fail_count + FW'(1);
            tmr_load = 1'b1;
          end
        end
      end
      ST_LOCKED: begin
        if (tmr_zero) begin
          state_nx = ST_IDLE;
          fail_nx  = '0;
          blink_nx = 1'b0;
          blk_load = 1'b1;
        end else if (blk_zero) begin
          blink_nx = ~led_blink;
          blk_load = 1'b1;
          blk_val  = BLINK_LD;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    unlocked   = (state == ST_UNLOCKED);
    locked_out = (state == ST_LOCKED);
  end

endmodule
